// File: rtl/lc3_pkg.sv
// Shared LC-3 control definitions: ISDU state encoding, opcodes and the
// datapath select encodings used by the register file and datapath.
package lc3_pkg;

    typedef enum logic [4:0] {
        ST_HALTED,
        ST_18,
        ST_33,
        ST_35,
        ST_32,
        ST_01,
        ST_05,
        ST_09,
        ST_00,
        ST_22,
        ST_12,
        ST_04,
        ST_21,
        ST_20,
        ST_06,
        ST_25,
        ST_27,
        ST_07,
        ST_23,
        ST_16,
        ST_PAUSE_IR1,
        ST_PAUSE_IR2
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_PSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] DRMUX_IR11_9 = 2'b00;
    localparam logic [1:0] DRMUX_R6     = 2'b01;
    localparam logic [1:0] DRMUX_R7     = 2'b10;

    localparam logic [1:0] SR1MUX_IR11_9 = 2'b00;
    localparam logic [1:0] SR1MUX_IR8_6  = 2'b01;
    localparam logic [1:0] SR1MUX_R6     = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    function automatic logic is_mem_state(state_t s);
        return (s == ST_33) || (s == ST_25) || (s == ST_16);
    endfunction

endpackage

// File: rtl/isdu_wait_ctr.sv
// SRAM wait counter: held at zero outside memory states, counts while in one,
// and flags the last cycle of the MEM_WAIT-cycle access.
module isdu_wait_ctr #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

    logic [2:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= 3'd0;
        else if (en)
            cnt <= cnt + 3'd1;
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/lc3_isdu.sv
// LC-3 instruction sequencing and decode unit: Moore control FSM driving the
// datapath loads, bus gates, mux selects and active-low SRAM strobes.
module lc3_isdu
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] DRMUX,
    output logic [1:0] SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic [4:0] state_dbg
);

    state_t state, next_state;
    logic   in_mem;
    logic   wait_done;

    assign in_mem    = is_mem_state(state);
    assign state_dbg = state;

    isdu_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait_ctr (
        .clk   (Clk),
        .reset (Reset),
        .clr   (!in_mem),
        .en    (in_mem),
        .done  (wait_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= ST_HALTED;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_HALTED:    if (Run) next_state = ST_18;
            ST_18:        next_state = ST_33;
            ST_33:        if (wait_done) next_state = ST_35;
            ST_35:        next_state = ST_32;
            ST_32: begin
                case (Opcode)
                    OP_ADD:  next_state = ST_01;
                    OP_AND:  next_state = ST_05;
                    OP_NOT:  next_state = ST_09;
                    OP_BR:   next_state = ST_00;
                    OP_JMP:  next_state = ST_12;
                    OP_JSR:  next_state = ST_04;
                    OP_LDR:  next_state = ST_06;
                    OP_STR:  next_state = ST_07;
                    OP_PSE:  next_state = ST_PAUSE_IR1;
                    default: next_state = ST_18;
                endcase
            end
            ST_00:        next_state = BEN ? ST_22 : ST_18;
            ST_04:        next_state = IR_11 ? ST_21 : ST_20;
            ST_06:        next_state = ST_25;
            ST_25:        if (wait_done) next_state = ST_27;
            ST_07:        next_state = ST_23;
            ST_23:        next_state = ST_16;
            ST_16:        if (wait_done) next_state = ST_18;
            // Waiting for Continue to drop stops a held button from stepping twice.
            ST_PAUSE_IR1: if (Continue) next_state = ST_PAUSE_IR2;
            ST_PAUSE_IR2: if (!Continue) next_state = ST_18;
            ST_01, ST_05, ST_09, ST_22, ST_12, ST_21, ST_20, ST_27:
                          next_state = ST_18;
            default:      next_state = ST_HALTED;
        endcase
    end

    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_INC;
        DRMUX      = DRMUX_IR11_9;
        SR1MUX     = SR1MUX_IR11_9;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALUK_ADD;
        MIO_EN     = 1'b0;
        Mem_CE     = 1'b1;
        Mem_UB     = 1'b1;
        Mem_LB     = 1'b1;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;

        // IR_5 is a bit of the instruction register, stable through execute.
        unique case (state)
            ST_18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                PCMUX  = PCMUX_INC;
                LD_PC  = 1'b1;
            end
            ST_33, ST_25: begin
                Mem_CE = 1'b0;
                Mem_OE = 1'b0;
                Mem_UB = 1'b0;
                Mem_LB = 1'b0;
                LD_MDR = 1'b1;
                MIO_EN = 1'b1;
            end
            ST_35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            ST_32: LD_BEN = 1'b1;
            ST_01, ST_05, ST_09: begin
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                GateALU = 1'b1;
                DRMUX   = DRMUX_IR11_9;
                SR1MUX  = SR1MUX_IR8_6;
                SR2MUX  = IR_5;
                ALUK    = (state == ST_01) ? ALUK_ADD :
                          (state == ST_05) ? ALUK_AND : ALUK_NOT;
            end
            ST_22: begin
                PCMUX    = PCMUX_ADDER;
                ADDR1MUX = 1'b0;
                ADDR2MUX = ADDR2_OFF9;
                LD_PC    = 1'b1;
            end
            ST_12: begin
                SR1MUX   = SR1MUX_IR8_6;
                ADDR1MUX = 1'b1;
                ADDR2MUX = ADDR2_ZERO;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            ST_04: begin
                DRMUX  = DRMUX_R7;
                GatePC = 1'b1;
                LD_REG = 1'b1;
            end
            ST_21: begin
                PCMUX    = PCMUX_ADDER;
                ADDR1MUX = 1'b0;
                ADDR2MUX = ADDR2_OFF11;
                LD_PC    = 1'b1;
            end
            ST_20: begin
                SR1MUX     = SR1MUX_IR8_6;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_ZERO;
                GateMARMUX = 1'b1;
                PCMUX      = PCMUX_BUS;
                LD_PC      = 1'b1;
            end
            ST_06, ST_07: begin
                SR1MUX     = SR1MUX_IR8_6;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_OFF6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            ST_27: begin
                GateMDR = 1'b1;
                DRMUX   = DRMUX_IR11_9;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            ST_23: begin
                SR1MUX  = SR1MUX_IR11_9;
                ALUK    = ALUK_PASS;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            ST_16: begin
                Mem_CE = 1'b0;
                Mem_WE = 1'b0;
                Mem_UB = 1'b0;
                Mem_LB = 1'b0;
            end
            ST_PAUSE_IR1: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_isdu.sv
// Directed bench for lc3_isdu: walks fetch/execute for each opcode class,
// pause/continue, and reset during a memory wait.
module tb_lc3_isdu;
    import lc3_pkg::*;

    localparam int MW = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [3:0] Opcode = 4'd0;
    logic       IR_5 = 1'b0;
    logic       IR_11 = 1'b0;
    logic       BEN = 1'b0;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK;
    logic       SR2MUX, ADDR1MUX, MIO_EN;
    logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic [4:0] state_dbg;

    int n_total = 0;
    int n_pass  = 0;

    lc3_isdu #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE),
        .Mem_WE(Mem_WE), .state_dbg(state_dbg)
    );

    // Clock/reset
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_state(input string tag, input state_t s);
        check(tag, 16'(state_dbg), 16'(s));
    endtask

    // Advance one clock and sample 1 time unit later; bus gates and SRAM
    // strobes are checked for exclusivity on every cycle.
    task automatic tick();
        @(posedge Clk);
        #1;
        check("gate_at_most_one",
              16'($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1), 16'd1);
        check("we_oe_exclusive", 16'(Mem_WE | Mem_OE), 16'd1);
    endtask

    // From S_18: MW cycles of S_33 read, then S_35, then S_32.
    task automatic fetch();
        for (int i = 0; i < MW; i++) begin
            tick();
            expect_state("fetch_s33", ST_33);
            check("s33_mem", 16'({Mem_CE, Mem_OE, Mem_UB, Mem_LB, Mem_WE}), 16'b00001);
            check("s33_ld", 16'({LD_MDR, MIO_EN}), 16'b11);
        end
        tick();
        expect_state("fetch_s35", ST_35);
        check("s35_ctl", 16'({GateMDR, LD_IR}), 16'b11);
        tick();
        expect_state("fetch_s32", ST_32);
        check("s32_ld_ben", 16'(LD_BEN), 16'd1);
    endtask

    initial begin : stimulus
        int we_low;

        // Reset and halted outputs
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tick();
        expect_state("halted_after_reset", ST_HALTED);
        check("halted_ld_gate", 16'({LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
              LD_LED, GatePC, GateMDR, GateALU, GateMARMUX, MIO_EN}), 16'd0);
        check("halted_mux", 16'({PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK}), 16'd0);
        check("halted_mem", 16'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 16'h1f);

        // Run -> S_18; Run stays high through the fetch and must be ignored
        Run = 1'b1;
        Opcode = OP_ADD;
        IR_5 = 1'b1;
        tick();
        expect_state("run_s18", ST_18);
        check("s18_ctl", 16'({LD_MAR, GatePC, LD_PC, PCMUX}), 16'b1110_0);
        fetch();
        Run = 1'b0;
        tick();
        expect_state("add_s01", ST_01);
        check("add_ld", 16'({LD_REG, LD_CC, GateALU}), 16'b111);
        check("add_mux", 16'({SR2MUX, ALUK, DRMUX, SR1MUX}), 16'b1_00_00_01);
        tick();
        expect_state("add_back_s18", ST_18);

        // JSR with IR_11=0 goes via S_20
        Opcode = OP_JSR;
        IR_11 = 1'b0;
        fetch();
        tick();
        expect_state("jsr_s04", ST_04);
        check("s04_ctl", 16'({DRMUX, GatePC, LD_REG}), 16'b10_1_1);
        tick();
        expect_state("jsr_s20", ST_20);
        check("s20_ctl", 16'({PCMUX, ADDR1MUX, LD_PC}), 16'b01_1_1);
        tick();
        expect_state("jsr_back_s18", ST_18);

        // JSR with IR_11=1 goes via S_21
        IR_11 = 1'b1;
        fetch();
        tick();
        expect_state("jsrr_s04", ST_04);
        tick();
        expect_state("jsr_s21", ST_21);
        check("s21_ctl", 16'({PCMUX, ADDR2MUX, LD_PC}), 16'b10_11_1);
        tick();
        expect_state("jsr21_back_s18", ST_18);

        // STR: Mem_WE low for exactly MW cycles, then a NOT instruction
        Opcode = OP_STR;
        fetch();
        tick();
        expect_state("str_s07", ST_07);
        check("s07_ctl", 16'({LD_MAR, GateMARMUX, ADDR2MUX}), 16'b1_1_01);
        tick();
        expect_state("str_s23", ST_23);
        check("s23_ctl", 16'({SR1MUX, LD_MDR, GateALU, ALUK}), 16'b00_1_1_11);
        Opcode = OP_NOT;
        we_low = 0;
        for (int i = 0; i < MW + 5; i++) begin
            tick();
            if (Mem_WE == 1'b0) begin
                we_low++;
                check("s16_mem", 16'({Mem_CE, Mem_UB, Mem_LB, Mem_OE}), 16'b0001);
            end
        end
        check("str_we_low_cycles", 16'(we_low), 16'(MW));
        expect_state("str_refetch_s35", ST_35);
        tick();
        expect_state("not_s32", ST_32);
        tick();
        expect_state("not_s09", ST_09);
        check("not_alu", 16'({ALUK, GateALU, LD_REG}), 16'b10_1_1);
        tick();
        expect_state("not_back_s18", ST_18);

        // AND with register operand
        Opcode = OP_AND;
        IR_5 = 1'b0;
        fetch();
        tick();
        expect_state("and_s05", ST_05);
        check("and_mux", 16'({SR2MUX, ALUK}), 16'b0_01);
        tick();

        // BR not taken, then taken
        Opcode = OP_BR;
        BEN = 1'b0;
        fetch();
        tick();
        expect_state("br_s00", ST_00);
        tick();
        expect_state("br_nt_s18", ST_18);
        BEN = 1'b1;
        fetch();
        tick();
        expect_state("br_s00_t", ST_00);
        tick();
        expect_state("br_s22", ST_22);
        check("s22_ctl", 16'({PCMUX, ADDR2MUX, LD_PC}), 16'b10_10_1);
        tick();

        // JMP, then an unimplemented opcode that returns straight to fetch
        Opcode = OP_JMP;
        fetch();
        tick();
        expect_state("jmp_s12", ST_12);
        check("s12_ctl", 16'({PCMUX, ADDR1MUX, LD_PC}), 16'b10_1_1);
        tick();
        Opcode = 4'b0010;
        fetch();
        tick();
        expect_state("other_op_s18", ST_18);

        // Pause with Continue held five cycles, then exactly one LDR fetch
        Opcode = OP_PSE;
        fetch();
        tick();
        expect_state("pause1", ST_PAUSE_IR1);
        check("pause1_led", 16'(LD_LED), 16'd1);
        tick();
        expect_state("pause1_hold", ST_PAUSE_IR1);
        Continue = 1'b1;
        Opcode = OP_LDR;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_state("pause2_hold", ST_PAUSE_IR2);
        end
        Continue = 1'b0;
        tick();
        expect_state("resume_s18", ST_18);
        fetch();
        tick();
        expect_state("ldr_s06", ST_06);
        tick();
        expect_state("ldr_s25_1", ST_25);
        tick();
        expect_state("ldr_s25_2", ST_25);
        check("s25_ld_mdr", 16'(LD_MDR), 16'd1);

        // Reset mid-wait, with Run asserted alongside it
        Reset = 1'b1;
        Run = 1'b1;
        tick();
        expect_state("reset_mid_wait", ST_HALTED);
        check("reset_mem", 16'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 16'h1f);
        check("reset_ld_mdr", 16'(LD_MDR), 16'd0);
        tick();
        expect_state("reset_beats_run", ST_HALTED);
        Reset = 1'b0;
        Run = 1'b0;
        tick();
        expect_state("idle_halted", ST_HALTED);
        Run = 1'b1;
        tick();
        expect_state("rerun_s18", ST_18);
        Run = 1'b0;
        Opcode = OP_ADD;
        fetch();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
